// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU/mux selects
// and the control FSM state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPE_EX,
        S_RTYPE_WB,
        S_ADDI_EX,
        S_ADDI_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

endpackage

// File: rtl/mips_mc_timeout.sv
// Memory wait timer: down-counter reloaded while the access is not stalling,
// expire flags the terminal count.
module mips_mc_timeout #(
    parameter int             TOW      = 5,
    parameter logic [TOW-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [TOW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LOAD_VAL;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready stalls, timeout and halt.
// Optional perf counters (instr_cnt/stall_cnt) under `MIPS_MC_PERF_CNT_EN.
//
// state      | meaning
// IDLE       | after reset, all strobes low
// FETCH      | read instruction at PC, PC+4 on mem_ready
// DECODE     | register read, branch target precompute, dispatch
// MEMADR     | lw/sw effective address
// MEMRD      | data read (stalls on mem_ready)
// MEMWB      | load write-back
// MEMWR      | data write (stalls on mem_ready)
// RTYPE_EX   | ALU op from funct
// RTYPE_WB   | R-type write-back to rd
// ADDI_EX    | A + immediate
// ADDI_WB    | addi write-back to rt
// BRANCH     | beq compare, PC load on zero
// JUMP       | PC load with jump address
// HALT       | illegal opcode or bus error, only rst exits
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int OPWDTH      = 6,
    parameter int FCWDTH      = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int TOW         = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPWDTH-1:0] opcode,
    input  logic [FCWDTH-1:0] funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic [1:0]        pc_source,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_wrt,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic              instr_done,
    output logic              halted,
    output logic              bus_err
`ifdef MIPS_MC_PERF_CNT_EN
    ,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    state_t state, state_nxt;
    logic   mem_state, waiting, expire, timeout;
    logic   pc_write, pc_write_cond;
    logic   funct_unused;

    // funct is decoded by the ALU control, not here
    assign funct_unused = ^funct;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign waiting   = mem_state && !mem_ready;
    assign timeout   = waiting && expire;

    // Reloaded whenever not stalling, so every memory state starts with a full budget
    mips_mc_timeout #(
        .TOW      (TOW),
        .LOAD_VAL (TOW'(MEM_TIMEOUT - 1))
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (!waiting),
        .en     (waiting),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_HALT;
            end
            S_DECODE: begin
                if (opcode == OPWDTH'(OP_RTYPE))                                   state_nxt = S_RTYPE_EX;
                else if (opcode == OPWDTH'(OP_LW) || opcode == OPWDTH'(OP_SW))     state_nxt = S_MEMADR;
                else if (opcode == OPWDTH'(OP_BEQ))                                state_nxt = S_BRANCH;
                else if (opcode == OPWDTH'(OP_J))                                  state_nxt = S_JUMP;
                else if (opcode == OPWDTH'(OP_ADDI))                               state_nxt = S_ADDI_EX;
                else                                                               state_nxt = S_HALT;
            end
            S_MEMADR: state_nxt = (opcode == OPWDTH'(OP_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)    state_nxt = S_MEMWB;
                else if (timeout) state_nxt = S_HALT;
            end
            S_MEMWR: begin
                if (mem_ready)    state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_HALT;
            end
            S_MEMWB, S_RTYPE_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            S_RTYPE_EX: state_nxt = S_RTYPE_WB;
            S_ADDI_EX:  state_nxt = S_ADDI_WB;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_wrt       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        instr_done    = 1'b0;
        halted        = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH2;
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_wrt    = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                reg_wrt    = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDI_WB: begin
                reg_wrt    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_source     = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
        pc_en = pc_write | (pc_write_cond & zero);
    end

`ifdef MIPS_MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else if (!halted) begin
            if (instr_done) instr_cnt <= instr_cnt + 32'd1;
            if (waiting)    stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: directed instructions push expected latency
// and write-back strobes; a monitor checks them on every instr_done pulse.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_wrt;
    logic       alu_src_a, instr_done, halted, bus_err;
    logic [1:0] pc_source, alu_src_b, alu_op;
`ifdef MIPS_MC_PERF_CNT_EN
    logic [31:0] instr_cnt, stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        int         lat;
        logic [7:0] ctl;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mips_mc_ctrl #(
        .OPWDTH      (6),
        .FCWDTH      (6),
        .MEM_TIMEOUT (16),
        .TOW         (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_wrt    (reg_wrt),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .halted     (halted),
        .bus_err    (bus_err)
`ifdef MIPS_MC_PERF_CNT_EN
        ,
        .instr_cnt  (instr_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    logic [17:0] outs;
    logic [7:0]  ctl_now;
    assign outs    = {pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                      mem_to_reg, reg_wrt, alu_src_a, alu_src_b, alu_op, instr_done, halted, bus_err};
    assign ctl_now = {reg_wrt, reg_dst, mem_to_reg, mem_write, pc_en, pc_source, bus_err};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction starts at the first FETCH sample; latency counts through instr_done.
    initial begin : monitor
        bit   in_instr = 0;
        int   lat      = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_instr = 0;
                lat      = 0;
            end else begin
                if (!in_instr && mem_read && !i_or_d) begin
                    in_instr = 1;
                    lat      = 0;
                end
                if (in_instr) lat++;
                if (instr_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_latency"}, lat, e.lat);
                        check({e.name, "_ctl"}, {24'd0, ctl_now}, {24'd0, e.ctl});
                    end
                    in_instr = 0;
                end
            end
        end
    end

    // Driven from the FETCH cycle (posedge+1); stalls go into FETCH and the data-memory state.
    task automatic run_instr(input string nm, input logic [5:0] op, input logic z,
                             input int fst, input int mst, input int base_lat, input logic [7:0] ctl);
        exp_t e;
        int   lat = base_lat + fst + mst;
        int   ms  = fst + 3;
        e.name = nm;
        e.lat  = lat;
        e.ctl  = ctl;
        sb.push_back(e);
        opcode = op;
        zero   = z;
        for (int c = 0; c < lat; c++) begin
            mem_ready = !((c < fst) || (c >= ms && c < ms + mst));
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
    endtask

    // Leaves the bench at posedge+1 inside the first FETCH cycle.
    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    localparam logic [7:0] CTL_RTYPE = 8'b1100_0000;
    localparam logic [7:0] CTL_LW    = 8'b1010_0000;
    localparam logic [7:0] CTL_SW    = 8'b0001_0000;
    localparam logic [7:0] CTL_ADDI  = 8'b1000_0000;
    localparam logic [7:0] CTL_BEQ_T = 8'b0000_1010;
    localparam logic [7:0] CTL_BEQ_N = 8'b0000_0010;
    localparam logic [7:0] CTL_J     = 8'b0000_1100;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [17:0] fetch_outs;
        fetch_outs = {1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                      2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        rst       = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_outs", {14'd0, outs}, 32'd0);
        end
        rst = 1'b0;
        check("idle_outs", {14'd0, outs}, 32'd0);
        @(posedge clk); #1;
        check("fetch_outs", {14'd0, outs}, {14'd0, fetch_outs});

        run_instr("rtype", 6'b000000, 1'b0, 0, 0, 4, CTL_RTYPE);
        run_instr("lw_stall3", 6'b100011, 1'b0, 0, 3, 5, CTL_LW);
        check("lw_no_bus_err", {31'd0, bus_err}, 32'd0);
        run_instr("beq_taken", 6'b000100, 1'b1, 0, 0, 3, CTL_BEQ_T);
        run_instr("beq_not_taken", 6'b000100, 1'b0, 0, 0, 3, CTL_BEQ_N);
        run_instr("addi", 6'b001000, 1'b0, 0, 0, 4, CTL_ADDI);
        run_instr("jump", 6'b000010, 1'b0, 0, 0, 3, CTL_J);
        run_instr("sw", 6'b101011, 1'b0, 0, 0, 4, CTL_SW);
        run_instr("sw_stall2", 6'b101011, 1'b0, 1, 2, 4, CTL_SW);

        // Illegal opcode: FETCH, DECODE, then HALT
        opcode = 6'b111111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            check("halt_outs", {14'd0, outs}, 32'd2);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("halt_cleared_by_rst", {31'd0, halted}, 32'd0);
        do_reset();

        // FETCH timeout: 16 wait cycles with mem_ready low
        mem_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 15) begin
                check("timeout_pre_flags", {30'd0, halted, bus_err}, 32'd0);
                check("timeout_pre_fetch", {31'd0, mem_read}, 32'd1);
            end
        end
        check("timeout_flags", {30'd0, halted, bus_err}, 32'd3);
        check("timeout_halt_outs", {14'd0, outs}, 32'd3);
        do_reset();
        check("bus_err_cleared", {31'd0, bus_err}, 32'd0);

        // mem_ready arrives on the 16th FETCH cycle: access completes
        run_instr("rtype_ready_at_limit", 6'b000000, 1'b0, 15, 0, 4, CTL_RTYPE);
        check("limit_no_bus_err", {30'd0, halted, bus_err}, 32'd0);

        // Reset while stalled in MEMWR
        opcode    = 6'b101011;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("memwr_active", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_sw_outs", {14'd0, outs}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold_outs", {14'd0, outs}, 32'd0);
        do_reset();

`ifdef MIPS_MC_PERF_CNT_EN
        check("perf_reset_instr", instr_cnt, 32'd0);
        run_instr("perf_sw", 6'b101011, 1'b0, 2, 0, 4, CTL_SW);
        run_instr("perf_addi", 6'b001000, 1'b0, 0, 0, 4, CTL_ADDI);
        run_instr("perf_j", 6'b000010, 1'b0, 0, 0, 3, CTL_J);
        check("perf_instr_cnt", instr_cnt, 32'd3);
        check("perf_stall_cnt", stall_cnt, 32'd2);
        opcode = 6'b001000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("perf_rst_instr", instr_cnt, 32'd0);
        check("perf_rst_stall", stall_cnt, 32'd0);
        do_reset();
`endif

        @(posedge clk); #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
